regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port register file for the pipelined core, with a per-register scoreboard.
//  Provides NRD combinational read ports, two write ports (A: ALU writeback, B: memory/late
//  writeback), same-cycle write-to-read bypass and hardwired-zero register 0. The scoreboard
//  is set at issue and cleared at writeback; decode uses rd_busy to stall on RAW hazards.
// PARAMETERS
//  DATA_W   32  register width in bits
//  NREGS    32  number of registers (power of 2, >=2); AW = $clog2(NREGS)
//  NRD      2   number of read ports (1..4)
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, never busy; 0: register 0 is ordinary
//  BYPASS   1   1: same-cycle write data forwarded to reads; 0: reads see array contents only
// PORTS
//  clk       in   1          clock, all state updates on rising edge
//  rst_n     in   1          asynchronous active-low reset
//  rd_addr   in   NRD*AW     read addresses, port i at [i*AW +: AW]
//  rd_data   out  NRD*DATA_W read data, port i at [i*DATA_W +: DATA_W]
//  rd_busy   out  NRD        1 = register addressed by port i has an outstanding write
//  wa_en     in   1          write port A enable
//  wa_addr   in   AW         write port A address
//  wa_data   in   DATA_W     write port A data
//  wb_en     in   1          write port B enable
//  wb_addr   in   AW         write port B address
//  wb_data   in   DATA_W     write port B data
//  iss_en    in   1          issue of an instruction with a destination register
//  iss_addr  in   AW         destination register being issued
//  busy_cnt  out  AW+1       registered count of registers with pending bit set
// BEHAVIOUR
//  - Reset (rst_n low, async): all registers 0, all pending bits 0, busy_cnt 0. Hence rd_data
//    0 and rd_busy 0 during reset. Reset mid-operation discards all writes and issues.
//  - Write: wX_en at rising edge stores wX_data into wX_addr; array visible from next cycle.
//  - Same address on A and B in one cycle: B wins (data and bypass). Different addresses: both.
//  - Read: combinational. BYPASS=1: if wb_en and wb_addr==rd_addr -> wb_data; else if wa_en and
//    wa_addr==rd_addr -> wa_data; else array. BYPASS=0: array only (old value in write cycle).
//  - ZERO_REG=1: address 0 -> rd_data 0 and rd_busy 0 regardless of writes/bypass/issue;
//    writes and issues to 0 are dropped (no state change, busy_cnt unaffected).
//  - Scoreboard: pending[r] set at edge when iss_en and iss_addr==r; cleared at edge when
//    any enabled write port targets r. Issue and write to same r in one cycle: set wins
//    (new producer), data still written. Issue to an already-pending reg: stays 1, no count change.
//  - rd_busy[i] = pending[rd_addr_i] & ~(write to rd_addr_i this cycle), when BYPASS=1; with
//    BYPASS=0 rd_busy[i] = pending[rd_addr_i] (write not yet visible).
//  - busy_cnt: next = popcount(next pending); registered, updates one cycle after the event,
//    range 0..NREGS (or NREGS-1 when ZERO_REG=1); no overflow/wrap possible.
//  - Write to non-pending register is legal (e.g. CSR-style writes): data stored, pending stays 0.
//  - No X propagation: unused port data ignored when its enable is low.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream after writing r5=0xDEADBEEF -> rd_data 0, rd_busy 0,
//    busy_cnt 0 immediately; after release r5 reads 0.
//  2 Write/read: wa r3=0x1234 at cycle n -> port0 reads 0x1234 in cycle n (bypass) and n+1
//    (array); BYPASS=0 build reads old value in cycle n.
//  3 Collision: wa r7=0xAAAA and wb r7=0x5555 same cycle -> r7 reads 0x5555 that cycle and after.
//  4 Zero reg: wa r0=0xFFFF_FFFF, iss r0 -> rd_data 0, rd_busy 0, busy_cnt unchanged.
//  5 Scoreboard: iss r4, r9 -> busy_cnt 2, rd_busy high for r4/r9; wb r4 -> rd_busy(r4)=0 in the
//    write cycle, busy_cnt 1 next cycle; iss r9 plus wa r9 same cycle -> r9 stays busy, data stored.
//  6 Fill: issue every register 1..NREGS-1 -> busy_cnt NREGS-1; write all -> busy_cnt 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file for the pipelined core, with a per-register scoreboard.
//
// Reads are combinational. There are two write ports: A for ALU writeback and B for
// memory/late writeback. When both ports write the same register in one cycle, port B wins.
// An optional same-cycle bypass forwards write data to the read ports, and register 0 can
// be hardwired to zero. A pending bit per register is set at issue and cleared at writeback.
// Decode uses rd_busy_o to stall on RAW hazards.
//
// Ports
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   rd_addr_i   NRD read addresses, port i at [i*AW +: AW]
//   rd_data_o   NRD read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy_o   per read port: addressed register has an outstanding write
//   wa_*_i      write port A (enable, address, data)
//   wb_*_i      write port B (enable, address, data)
//   iss_en_i    issue of an instruction with destination iss_addr_i
//   busy_cnt_o  registered count of pending registers
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NRD*AW-1:0]     rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  wa_en_i,
  input  logic [AW-1:0]         wa_addr_i,
  input  logic [DATA_W-1:0]     wa_data_i,
  input  logic                  wb_en_i,
  input  logic [AW-1:0]         wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic                  iss_en_i,
  input  logic [AW-1:0]         iss_addr_i,
  output logic [AW:0]           busy_cnt_o
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [AW:0]       busy_cnt_q, busy_cnt_d;

  logic wa_eff, wb_eff, iss_eff;

  // With a hardwired zero register, anything aimed at r0 is dropped before it reaches state.
  always_comb begin
    wa_eff  = wa_en_i;
    wb_eff  = wb_en_i;
    iss_eff = iss_en_i;
    if (ZERO_REG) begin
      if (wa_addr_i == '0)  wa_eff  = 1'b0;
      if (wb_addr_i == '0)  wb_eff  = 1'b0;
      if (iss_addr_i == '0) iss_eff = 1'b0;
    end
  end

  // Register array. Port B has priority over port A on an address collision.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wb_eff && wb_addr_i == AW'(r))      regs_q[r] <= wb_data_i;
        else if (wa_eff && wa_addr_i == AW'(r)) regs_q[r] <= wa_data_i;
      end
    end
  end

  // Scoreboard next state. A write clears the pending bit and an issue sets it.
  // When both happen in the same cycle, the issue wins because a newer producer is in flight.
  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < NREGS; r++) begin
      if ((wa_eff && wa_addr_i == AW'(r)) || (wb_eff && wb_addr_i == AW'(r)))
        pending_d[r] = 1'b0;
      if (iss_eff && iss_addr_i == AW'(r))
        pending_d[r] = 1'b1;
    end
    if (ZERO_REG) pending_d[0] = 1'b0;
    busy_cnt_d = (AW+1)'($countones(pending_d));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  // Read ports. Port B's bypass is applied last, so it takes priority over port A.
  // A register being written this cycle is about to become valid, so it is not reported busy.
  always_comb begin
    logic [AW-1:0]     raddr;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      raddr = rd_addr_i[i*AW +: AW];
      rdata = regs_q[raddr];
      rbusy = pending_q[raddr];
      if (BYPASS) begin
        if (wa_en_i && wa_addr_i == raddr) begin
          rdata = wa_data_i;
          rbusy = 1'b0;
        end
        if (wb_en_i && wb_addr_i == raddr) begin
          rdata = wb_data_i;
          rbusy = 1'b0;
        end
      end
      if (ZERO_REG && raddr == '0) begin
        rdata = '0;
        rbusy = 1'b0;
      end
      rd_data_o[i*DATA_W +: DATA_W] = rdata;
      rd_busy_o[i]                  = rbusy;
    end
  end

endmodule
